// File: rtl/osd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : osd_sequencer_pkg
// Purpose : Shared geometry constants, FSM encoding and width helper for the
//           OSD character sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package osd_sequencer_pkg;

    localparam int c_CELL_W     = 16;
    localparam int c_GLYPH_ROWS = 8;
    localparam int c_CNT_W      = 4;
    localparam int c_COORD_W    = 10;
    localparam int c_LEN_W      = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : osd_sequencer_if
// Purpose : Beam position, window configuration and datapath control bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface osd_sequencer_if #(
    parameter int NUM_WIN = 4,
    parameter int MAX_LEN = 16
) ();
    import osd_sequencer_pkg::*;

    localparam int SEL_W  = idx_w(NUM_WIN);
    localparam int ADDR_W = idx_w(MAX_LEN);

    logic                           pix_en;
    logic [c_COORD_W-1:0]           vga_x;
    logic [c_COORD_W-1:0]           vga_y;
    logic [NUM_WIN-1:0]             win_en;
    logic [NUM_WIN-1:0]             win_blink;
    logic [c_COORD_W*NUM_WIN-1:0]   win_x;
    logic [c_COORD_W*NUM_WIN-1:0]   win_y;
    logic [c_LEN_W*NUM_WIN-1:0]     win_len;
    logic [SEL_W-1:0]               win_sel;
    logic [ADDR_W-1:0]              buf_addr;
    logic [2:0]                     line_addr;
    logic                           load;
    logic                           shift_en;
    logic                           osd_active;

    modport slave (
        input  pix_en, vga_x, vga_y, win_en, win_blink, win_x, win_y, win_len,
        output win_sel, buf_addr, line_addr, load, shift_en, osd_active
    );

    modport master (
        output pix_en, vga_x, vga_y, win_en, win_blink, win_x, win_y, win_len,
        input  win_sel, buf_addr, line_addr, load, shift_en, osd_active
    );

endinterface
`default_nettype wire

// File: rtl/osd_sequencer_window_select.sv
`default_nettype none
// ============================================================================
// Module  : osd_window_select
// Purpose : Combinational priority hit test of the scanline against all
//           windows; returns the owner, its glyph row and its geometry.
// Revision: 1.0 - initial release
// ============================================================================
module osd_window_select
    import osd_sequencer_pkg::*;
#(
    parameter int NUM_WIN  = 4,
    parameter int LINE_REP = 4,
    parameter int SEL_W    = 2
) (
    input  wire logic [c_COORD_W-1:0]         i_vga_y,
    input  wire logic [NUM_WIN-1:0]           i_win_en,
    input  wire logic [c_COORD_W*NUM_WIN-1:0] i_win_x,
    input  wire logic [c_COORD_W*NUM_WIN-1:0] i_win_y,
    input  wire logic [c_LEN_W*NUM_WIN-1:0]   i_win_len,
    output logic                              o_hit,
    output logic [SEL_W-1:0]                  o_sel,
    output logic [2:0]                        o_line_addr,
    output logic [c_COORD_W-1:0]              o_win_x,
    output logic [c_LEN_W-1:0]                o_win_len
);

    localparam int REP_LOG2 = $clog2(LINE_REP);
    localparam int DY_W     = c_COORD_W + 1;
    localparam int ROWS_H   = c_GLYPH_ROWS * LINE_REP;

    logic [NUM_WIN-1:0] w_hit;
    logic [2:0]         w_row [NUM_WIN];

    for (genvar gi = 0; gi < NUM_WIN; gi++) begin : g_win
        logic [c_COORD_W-1:0] w_top;
        logic [DY_W-1:0]      w_dy;

        assign w_top      = i_win_y[gi*c_COORD_W +: c_COORD_W];
        assign w_dy       = {1'b0, i_vga_y} - {1'b0, w_top};
        assign w_hit[gi]  = i_win_en[gi]
                         && (i_win_len[gi*c_LEN_W +: c_LEN_W] != '0)
                         && (i_vga_y >= w_top)
                         && (w_dy < DY_W'(ROWS_H));
        assign w_row[gi]  = 3'(w_dy >> REP_LOG2);
    end

    // Descending scan so the lowest-indexed hit wins.
    always_comb begin
        o_hit       = 1'b0;
        o_sel       = '0;
        o_line_addr = '0;
        o_win_x     = '0;
        o_win_len   = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                o_hit       = 1'b1;
                o_sel       = SEL_W'(i);
                o_line_addr = w_row[i];
                o_win_x     = i_win_x[i*c_COORD_W +: c_COORD_W];
                o_win_len   = i_win_len[i*c_LEN_W +: c_LEN_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/osd_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : osd_sequencer
// Purpose : Per-scanline window arbitration and per-cell sequencing of the
//           shared OSD character datapath. Optional macro OSD_BLINK_EN adds a
//           frame counter that gates blinking windows.
// Revision: 1.0 - initial release
// ============================================================================
module osd_sequencer
    import osd_sequencer_pkg::*;
#(
    parameter int NUM_WIN    = 4,
    parameter int MAX_LEN    = 16,
    parameter int LINE_REP   = 4,
    parameter int BLINK_LOG2 = 5
) (
    input  wire logic          clk,
    input  wire logic          reset,
    osd_sequencer_if.slave     bus
);

    localparam int SEL_W  = idx_w(NUM_WIN);
    localparam int ADDR_W = idx_w(MAX_LEN);

    state_t                 r_state, w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]      r_buf_addr, w_buf_nxt;
    logic [2:0]             r_line_addr, w_line_nxt;
    logic [SEL_W-1:0]       r_win_sel, w_sel_nxt;
    logic [c_COORD_W-1:0]   r_win_x, w_wx_nxt;
    logic [c_LEN_W-1:0]     r_win_len, w_wl_nxt;

    logic                   w_latch;
    logic [NUM_WIN-1:0]     w_en_eff;
    logic                   w_hit;
    logic [SEL_W-1:0]       w_sel;
    logic [2:0]             w_row;
    logic [c_COORD_W-1:0]   w_win_x;
    logic [c_LEN_W-1:0]     w_win_len;
    logic                   w_load, w_shift_en, w_active;

    assign w_latch = bus.pix_en && (bus.vga_x == '0);

`ifdef OSD_BLINK_EN
    logic [BLINK_LOG2:0] r_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0;
        end else if (w_latch && (bus.vga_y == '0)) begin
            r_frame <= r_frame + 1'b1;
        end
    end

    assign w_en_eff = bus.win_en & ~(bus.win_blink & {NUM_WIN{r_frame[BLINK_LOG2]}});
`else
    logic w_unused_blink;
    assign w_unused_blink = ^bus.win_blink;
    assign w_en_eff       = bus.win_en;
`endif

    osd_window_select #(
        .NUM_WIN  (NUM_WIN),
        .LINE_REP (LINE_REP),
        .SEL_W    (SEL_W)
    ) u_select (
        .i_vga_y     (bus.vga_y),
        .i_win_en    (w_en_eff),
        .i_win_x     (bus.win_x),
        .i_win_y     (bus.win_y),
        .i_win_len   (bus.win_len),
        .o_hit       (w_hit),
        .o_sel       (w_sel),
        .o_line_addr (w_row),
        .o_win_x     (w_win_x),
        .o_win_len   (w_win_len)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_buf_addr  <= '0;
            r_line_addr <= '0;
            r_win_sel   <= '0;
            r_win_x     <= '0;
            r_win_len   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_buf_addr  <= w_buf_nxt;
            r_line_addr <= w_line_nxt;
            r_win_sel   <= w_sel_nxt;
            r_win_x     <= w_wx_nxt;
            r_win_len   <= w_wl_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_buf_nxt   = r_buf_addr;
        w_line_nxt  = r_line_addr;
        w_sel_nxt   = r_win_sel;
        w_wx_nxt    = r_win_x;
        w_wl_nxt    = r_win_len;
        w_load      = (r_state == ST_LOAD);
        w_active    = (r_state == ST_SHIFT);
        w_shift_en  = (r_state == ST_SHIFT) && bus.pix_en;

        // The line latch overrides everything, which is what cuts a window
        // that runs past the right edge.
        if (w_latch) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_buf_nxt   = '0;
            w_sel_nxt   = '0;
            w_line_nxt  = '0;
            if (w_hit) begin
                w_sel_nxt  = w_sel;
                w_line_nxt = w_row;
                w_wx_nxt   = w_win_x;
                w_wl_nxt   = w_win_len;
                if (w_win_x == '0) begin
                    // Pixel 0 is consumed by the latch; start one pixel in so
                    // later cells stay on the 16-pixel grid.
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = c_CNT_W'(1);
                end else begin
                    w_state_nxt = ST_ARM;
                end
            end
        end else begin
            case (r_state)
                ST_ARM: begin
                    if (bus.pix_en && (bus.vga_x == r_win_x - 1'b1)) begin
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_state_nxt = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (bus.pix_en) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (r_cnt == c_CNT_W'(c_CELL_W - 1)) begin
                            if (c_LEN_W'(r_buf_addr) == r_win_len - 1'b1) begin
                                w_state_nxt = ST_DONE;
                                w_buf_nxt   = '0;
                            end else begin
                                w_state_nxt = ST_LOAD;
                                w_buf_nxt   = r_buf_addr + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign bus.win_sel    = r_win_sel;
    assign bus.buf_addr   = r_buf_addr;
    assign bus.line_addr  = r_line_addr;
    assign bus.load       = w_load;
    assign bus.shift_en   = w_shift_en;
    assign bus.osd_active = w_active;

endmodule
`default_nettype wire
